// File: rtl/hms_pkg.sv
// hms_pkg: shared constants and time type for the hms_counter slice
//   SEC_MOD/MIN_MOD: second and minute moduli
//   SEC_W/MIN_W/HOUR_W: field widths
//   hms_t: packed {hour, min, sec}, used for time and alarm values
package hms_pkg;
    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;
    localparam int SEC_W   = 6;
    localparam int MIN_W   = 6;
    localparam int HOUR_W  = 5;
    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
    } hms_t;
endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulo-MOD counter with synchronous load and carry-out
//   clk, rst    : clock, synchronous active-high reset
//   inc         : advance by one (load has priority)
//   ld, ld_val  : synchronous load of ld_val
//   q           : current count, always 0..MOD-1
//   wrap        : combinational carry-out, inc while q == MOD-1
module mod_counter #(
    parameter int MOD = 60,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] q,
    output logic         wrap
);
    assign wrap = inc && (q == W'(MOD - 1));

    always_ff @(posedge clk)
        if (rst)
            q <= '0;
        else
            q <= ld ? ld_val : wrap ? '0 : inc ? q + 1'b1 : q;
endmodule

// File: rtl/hms_counter.sv
// hms_counter: binary hours:minutes:seconds time-of-day counter driven by a 1 Hz tick
//   clk, rst                      : clock, synchronous active-high reset
//   tick_in                       : 1 Hz square wave; each rising edge is one second
//   load, load_hour/min/sec       : strobe to load time; out-of-range loads are rejected
//   hour, min, sec                : current time
//   min_wrap, day_wrap, load_err  : registered one-cycle pulses
//   Optional (HMS_ALARM_EN): alarm_load, alarm_hour, alarm_min, alarm_clr, alarm
module hms_counter
    import hms_pkg::*;
#(
    parameter int HOUR_MOD = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_in,
    input  logic              load,
    input  logic [HOUR_W-1:0] load_hour,
    input  logic [MIN_W-1:0]  load_min,
    input  logic [SEC_W-1:0]  load_sec,
`ifdef HMS_ALARM_EN
    input  logic              alarm_load,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MIN_W-1:0]  alarm_min,
    input  logic              alarm_clr,
    output logic              alarm,
`endif
    output logic [HOUR_W-1:0] hour,
    output logic [MIN_W-1:0]  min,
    output logic [SEC_W-1:0]  sec,
    output logic              min_wrap,
    output logic              day_wrap,
    output logic              load_err
);
    hms_t cur;
    logic tick_q, step, inc, load_ok, ld, sec_c, min_c, hour_c;

    // tick_q resets high so a level already high at reset release is not a tick
    assign step    = tick_in & ~tick_q;
    assign inc     = step & ~load;
    assign load_ok = load_sec <= SEC_W'(SEC_MOD - 1) && load_min <= MIN_W'(MIN_MOD - 1) &&
                     load_hour < HOUR_W'(HOUR_MOD);
    assign ld      = load & load_ok;

    mod_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
        .clk(clk), .rst(rst), .inc(inc), .ld(ld), .ld_val(load_sec), .q(cur.sec), .wrap(sec_c)
    );
    mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
        .clk(clk), .rst(rst), .inc(sec_c), .ld(ld), .ld_val(load_min), .q(cur.min), .wrap(min_c)
    );
    mod_counter #(.MOD(HOUR_MOD), .W(HOUR_W)) u_hour (
        .clk(clk), .rst(rst), .inc(min_c), .ld(ld), .ld_val(load_hour), .q(cur.hour), .wrap(hour_c)
    );

    assign hour = cur.hour;
    assign min  = cur.min;
    assign sec  = cur.sec;

    always_ff @(posedge clk)
        if (rst) begin
            tick_q   <= 1'b1;
            min_wrap <= 1'b0;
            day_wrap <= 1'b0;
            load_err <= 1'b0;
        end else begin
            tick_q   <= tick_in;
            min_wrap <= sec_c;
            day_wrap <= hour_c;
            load_err <= load & ~load_ok;
        end

`ifdef HMS_ALARM_EN
    hms_t alarm_q, nxt;

    // time after this cycle's step, so the alarm rises together with the new time
    assign nxt = '{hour: hour_c ? '0 : min_c ? cur.hour + 1'b1 : cur.hour,
                   min:  min_c  ? '0 : sec_c ? cur.min + 1'b1  : cur.min,
                   sec:  sec_c  ? '0 : cur.sec + 1'b1};

    always_ff @(posedge clk)
        if (rst) begin
            alarm_q <= '0;
            alarm   <= 1'b0;
        end else begin
            if (alarm_load)
                alarm_q <= '{hour: alarm_hour, min: alarm_min, sec: '0};
            alarm <= alarm_clr ? 1'b0 : (inc && nxt == alarm_q) ? 1'b1 : alarm;
        end
`endif
endmodule

// File: tb/tb_hms_counter.sv
// tb_hms_counter: directed plus randomized check of hms_counter (HOUR_MOD 24 and 12) against a seconds-of-day model
module tb_hms_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1, tick_in = 1'b1, load = 1'b0;
    logic [4:0] lh = '0;
    logic [5:0] lm = '0, ls = '0;
    logic [4:0] hour_a, hour_b;
    logic [5:0] min_a, min_b, sec_a, sec_b;
    logic       mw_a, mw_b, dw_a, dw_b, le_a, le_b;
    int checks = 0, errors = 0;
    int mods[2] = '{24, 12};
    int t[2];
    bit mw[2], dw[2], le[2], prev[2];
    int n_mw;
`ifdef HMS_ALARM_EN
    logic       aload = 1'b0, aclr = 1'b0, alarm_a, alarm_b;
    logic [4:0] ahi = '0;
    logic [5:0] ami = '0;
    int ah = 0, am = 0;
    bit al[2];
`endif

    always #5 clk = ~clk;

    hms_counter #(.HOUR_MOD(24)) dut_a (
        .clk(clk), .rst(rst), .tick_in(tick_in), .load(load),
        .load_hour(lh), .load_min(lm), .load_sec(ls),
`ifdef HMS_ALARM_EN
        .alarm_load(aload), .alarm_hour(ahi), .alarm_min(ami), .alarm_clr(aclr), .alarm(alarm_a),
`endif
        .hour(hour_a), .min(min_a), .sec(sec_a), .min_wrap(mw_a), .day_wrap(dw_a), .load_err(le_a)
    );
    hms_counter #(.HOUR_MOD(12)) dut_b (
        .clk(clk), .rst(rst), .tick_in(tick_in), .load(load),
        .load_hour(lh), .load_min(lm), .load_sec(ls),
`ifdef HMS_ALARM_EN
        .alarm_load(aload), .alarm_hour(ahi), .alarm_min(ami), .alarm_clr(aclr), .alarm(alarm_b),
`endif
        .hour(hour_b), .min(min_b), .sec(sec_b), .min_wrap(mw_b), .day_wrap(dw_b), .load_err(le_b)
    );

    // Reference: time kept as seconds since midnight, advanced with plain modular arithmetic
    task automatic model();
        bit stp, hit;
        for (int i = 0; i < 2; i++) begin
            hit = 1'b0;
            if (rst) begin
                t[i] = 0; mw[i] = 0; dw[i] = 0; le[i] = 0; prev[i] = 1;
            end else begin
                stp = tick_in && !prev[i];
                prev[i] = tick_in;
                mw[i] = 0; dw[i] = 0; le[i] = 0;
                if (load) begin
                    if (ls <= 59 && lm <= 59 && int'(lh) < mods[i]) t[i] = lh * 3600 + lm * 60 + ls;
                    else le[i] = 1;
                end else if (stp) begin
                    t[i] = (t[i] + 1) % (mods[i] * 3600);
                    mw[i] = (t[i] % 60) == 0;
                    dw[i] = t[i] == 0;
`ifdef HMS_ALARM_EN
                    hit = t[i] / 3600 == ah && (t[i] / 60) % 60 == am && t[i] % 60 == 0;
`endif
                end
            end
`ifdef HMS_ALARM_EN
            if (rst || aclr) al[i] = 0;
            else if (hit) al[i] = 1;
`endif
        end
`ifdef HMS_ALARM_EN
        if (rst) begin ah = 0; am = 0; end
        else if (aload) begin ah = ahi; am = ami; end
`endif
    endtask

    task automatic chk(string tag);
        logic [19:0] obs, exp;
        for (int i = 0; i < 2; i++) begin
            obs = i == 0 ? {hour_a, min_a, sec_a, mw_a, dw_a, le_a} : {hour_b, min_b, sec_b, mw_b, dw_b, le_b};
            exp = {5'(t[i] / 3600), 6'((t[i] / 60) % 60), 6'(t[i] % 60), mw[i], dw[i], le[i]};
            checks++;
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s dut%0d hms/mw/dw/le observed %h expected %h", tag, i, obs, exp);
            end
`ifdef HMS_ALARM_EN
            checks++;
            assert ((i == 0 ? alarm_a : alarm_b) === al[i]) else begin
                errors++;
                $error("FAIL %s_alarm dut%0d observed %b expected %b", tag, i, i == 0 ? alarm_a : alarm_b, al[i]);
            end
`endif
        end
    endtask

    task automatic eq(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(string tag);
        @(posedge clk);
        model();
        #1;
        chk(tag);
    endtask

    task automatic do_load(int h, int m, int s);
        lh = 5'(h); lm = 6'(m); ls = 6'(s); load = 1'b1;
        cyc("load");
        load = 1'b0;
    endtask

    initial begin
        t = '{0, 0}; prev = '{1, 1};
        // reset with tick held high, then release: the high level is not a tick
        repeat (10) cyc("reset");
        rst = 1'b0;
        repeat (3) cyc("release");
        eq("no_count_at_release", sec_a, 0);
        // 60 ticks, period 4 cycles
        n_mw = 0;
        for (int k = 0; k < 60; k++) begin
            tick_in = 1'b0; cyc("tick_lo"); cyc("tick_lo");
            tick_in = 1'b1; cyc("tick_hi"); n_mw += mw_a; cyc("tick_hi"); n_mw += mw_a;
        end
        eq("sec_after_60", sec_a, 0);
        eq("min_after_60", min_a, 1);
        eq("min_wrap_count", n_mw, 1);
        // day wrap, 24 h then 12 h
        tick_in = 1'b0;
        do_load(23, 59, 59);
        tick_in = 1'b1; cyc("day_wrap24");
        eq("day_wrap24_pulse", dw_a, 1);
        eq("day_wrap24_hour", hour_a, 0);
        tick_in = 1'b0; cyc("after_wrap");
        eq("day_wrap24_one_cycle", dw_a, 0);
        do_load(11, 59, 59);
        tick_in = 1'b1; cyc("day_wrap12");
        eq("day_wrap12_pulse", dw_b, 1);
        eq("no_day_wrap24_at_12", dw_a, 0);
        tick_in = 1'b0;
        // load rejection
        do_load(12, 60, 0);
        eq("load_err_min60", le_a, 1);
        eq("time_kept_min60", hour_a, 12);
        do_load(24, 0, 0);
        eq("load_err_hour24", le_a, 1);
        cyc("err_clear");
        // load and tick edge together
        tick_in = 1'b1;
        do_load(5, 6, 7);
        eq("load_beats_tick", sec_a, 7);
        eq("load_no_wrap", mw_a, 0);
        cyc("post_load_high");
        // long-high tick, then reset mid-count
        tick_in = 1'b0;
        do_load(1, 2, 2);
        tick_in = 1'b1;
        repeat (20) cyc("long_high");
        eq("long_high_one_step", sec_a, 3);
        rst = 1'b1; cyc("mid_reset");
        eq("mid_reset_min", min_a, 0);
        rst = 1'b0; tick_in = 1'b0; cyc("post_reset");
`ifdef HMS_ALARM_EN
        ahi = 5'd0; ami = 6'd1; aload = 1'b1; cyc("alarm_load");
        aload = 1'b0;
        do_load(0, 0, 59);
        eq("alarm_not_from_load", alarm_a, 0);
        tick_in = 1'b1; cyc("alarm_set");
        eq("alarm_rises", alarm_a, 1);
        tick_in = 1'b0; cyc("alarm_hold");
        aclr = 1'b1; cyc("alarm_clr");
        eq("alarm_falls", alarm_a, 0);
        aclr = 1'b0;
`endif
        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            tick_in = 1'($urandom_range(0, 1));
            rst = $urandom_range(0, 299) == 0;
            load = $urandom_range(0, 19) == 0;
            if ($urandom_range(0, 1) == 1) begin
                lh = 5'($urandom); lm = 6'($urandom); ls = 6'($urandom);
            end else begin
                lh = 5'($urandom_range(10, 23)); lm = 6'd59; ls = 6'($urandom_range(50, 59));
            end
`ifdef HMS_ALARM_EN
            aload = $urandom_range(0, 49) == 0;
            ahi = 5'($urandom_range(0, 23)); ami = 6'($urandom_range(0, 1) == 1 ? 0 : 59);
            aclr = $urandom_range(0, 39) == 0;
`endif
            cyc("random");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hms_counter.md
# hms_counter

Time-of-day counter that sits directly downstream of `nco`. It consumes the `clk_gen` square wave that `nco` produces, which is 1 Hz when `num` = 50_000_000 at a 50 MHz `clk`. Each rising edge of `clk_gen` is one one-second tick, and the block advances a BCD-free binary hours:minutes:seconds count from it. It provides synchronous time load, wrap pulses for downstream display/driver stages, and an optional alarm.

## Interface

Parameters:
- `HOUR_MOD`, 24, hour wrap modulus (24 or 12). Hours count 0..HOUR_MOD-1.

Ports:
- `clk`  in  1  system clock, 50 MHz; `nco` runs on the same clock.
- `rst`  in  1  synchronous, active-high reset.
- `tick_in`  in  1  `clk_gen` from `nco`; synchronous to `clk`; high and low phases each ≥1 `clk` cycle.
- `load`  in  1  single-cycle strobe; load time fields below.
- `load_hour`  in  5  hour to load.
- `load_min`  in  6  minute to load.
- `load_sec`  in  6  second to load.
- `hour`  out  5  current hour.
- `min`  out  6  current minute.
- `sec`  out  6  current second.
- `min_wrap`  out  1  1-cycle pulse when sec wraps 59→0.
- `day_wrap`  out  1  1-cycle pulse when time wraps (HOUR_MOD-1):59:59→0:00:00.
- `load_err`  out  1  1-cycle pulse when a load is rejected.
- `ALARM_EN` only: `alarm_load` in 1, `alarm_hour` in 5, `alarm_min` in 6, `alarm_clr` in 1, `alarm` out 1.

## Operation

- Edge detect uses register `tick_q`, which samples `tick_in` every cycle. `step = tick_in & ~tick_q`.
- `tick_q` resets to 1. If `tick_in` is already high at reset release, that level is not counted.
- On a cycle with `step` and no `load`:
  - sec increments.
  - At 59, sec goes to 0, min increments, and `min_wrap` = 1.
  - At min 59 with sec wrap, min goes to 0 and hour increments.
  - At hour HOUR_MOD-1 with min wrap, hour goes to 0 and `day_wrap` = 1.
- A load is accepted only if `load_sec` ≤ 59, `load_min` ≤ 59 and `load_hour` < HOUR_MOD. When accepted, all three fields are written atomically.
- A rejected load leaves time unchanged and pulses `load_err`.
- `load` and `step` in the same cycle: `load` wins and the tick is dropped. This also applies when the load is rejected.
- A load never generates `min_wrap` or `day_wrap`.
- Each counter is modulo-N. No field ever holds an out-of-range value.

## Timing

- Reset values: hour = min = sec = 0, `min_wrap` = `day_wrap` = `load_err` = 0, `alarm` = 0, alarm registers = 0.
- Reset asserted mid-count clears all state at the next edge. Reset overrides `load` and `step`.
- Latency: at the first `clk` edge that samples `tick_in` = 1 after a low sample, sec updates. The new value is visible from that edge, with no further latency.
- Wrap pulses are registered and assert in the same cycle as the wrapped values.
- Load latency: fields update at the edge that samples `load` = 1. `load_err` asserts at that same edge.
- A continuously high `tick_in` produces exactly one step.

## Configuration

- `HMS_ALARM_EN` defined:
  - `alarm_load` captures `alarm_hour` and `alarm_min` without range checking. An unmatched value simply never fires.
  - `alarm` sets when a `step` moves time to alarm_hour:alarm_min:00.
  - `alarm` stays high until `alarm_clr` or `rst`.
  - `alarm_clr` in the same cycle as a set: clear wins.
  - A time load to the alarm time does not set `alarm`.
- `HMS_ALARM_EN` undefined: the alarm ports and logic are absent. All other behaviour is identical.

## Structure

- Package `hms_pkg` holds:
  - constants `SEC_MOD` = 60, `MIN_MOD` = 60.
  - width localparams `SEC_W` = 6, `MIN_W` = 6, `HOUR_W` = 5.
  - typedef `hms_t` as a packed struct {hour, min, sec}, used for time and alarm values.
- Sub-module `mod_counter` is parameterised by modulus and width. It has inputs `clk`, `rst`, `inc`, `ld` and `ld_val`, and outputs `q` and `wrap` (combinational carry-out when `q` = modulus-1 and `inc`). It is instantiated three times and chained by carry.

## Test plan

- Reset and sec wrap:
  - Stimulus: hold `rst` 10 cycles with `tick_in` high, release, then apply 60 ticks (tick period 4 cycles).
  - Expected: no count at release; after 60 ticks sec = 0, min = 1; `min_wrap` pulses exactly once.
- Day wrap:
  - Stimulus: load 23:59:59, then one tick.
  - Expected: 0:00:00, `day_wrap` = 1 for one cycle; with HOUR_MOD = 12, loading 11:59:59 behaves the same.
- Load rejection:
  - Stimulus: load 12:60:00.
  - Expected: `load_err` pulses; time unchanged. Load 24:00:00 with HOUR_MOD = 24 is also rejected.
- Simultaneous load and tick:
  - Stimulus: `load` of 05:06:07 in the same cycle as a tick edge.
  - Expected: time = 05:06:07, not 05:06:08; no wrap pulse.
- Long-high tick and mid-operation reset:
  - Stimulus: `tick_in` high for 20 cycles, then `rst` while time = 01:02:03.
  - Expected: exactly one step from the long-high tick; after the reset edge, all outputs are 0.
- Alarm (`HMS_ALARM_EN`):
  - Stimulus: alarm 00:01; load 00:00:59; tick once; then assert `alarm_clr`.
  - Expected: `alarm` rises with the tick and falls at the edge sampling `alarm_clr`.
